// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive sweep generator.
//   state_t      : controller states (IDLE, SETTLE, DONE)
//   DEFAULT_POLY : default MISR feedback taps
//   gray_of()    : binary-to-Gray conversion of a sweep index (up to 16 bits)
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h002D;

    function automatic logic [15:0] gray_of(input logic [15:0] i);
        return i ^ (i >> 1);
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Serial-input MISR used to compact the sampled DUT responses.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : shift one response word in on this edge
//   din        : response word, zero-extended to SIG_W before folding in
//   sig        : current signature
module sweep_misr
    import sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
    parameter int               DW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DW-1:0]     din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] din_ext;
    logic [SIG_W-1:0] sig_next;

    always_comb begin
        din_ext          = '0;
        din_ext[DW-1:0]  = din;
        sig_next         = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/exhaustive_sweep_gen.sv
// Exhaustive input sweep for a combinational block under test.
// Drives all 2^IN_W vectors (binary or Gray order), holds each HOLD cycles,
// samples the response at the end of the hold, streams (index, response)
// and compacts the responses into a MISR signature.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; outputs hold their last values
//   SETTLE | vector applied, counting hold cycles, sampling on the last one
//   DONE   | full sweep finished; signature final, done=1 until next start
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start        : begin a sweep (accepted in IDLE or DONE)
//   abort        : cancel a sweep in progress (SETTLE only)
//   gray_mode    : order select, captured when start is accepted
//   vec_out      : vector driven to the DUT
//   dut_resp     : DUT response, sampled directly
//   busy         : high while sweeping
//   done         : high after a completed sweep
//   sample_valid : one-cycle strobe per sampled vector
//   sample_idx   : binary sweep index of the sample
//   sample_resp  : captured response of the sample
//   signature    : MISR state
module exhaustive_sweep_gen
    import sweep_pkg::*;
#(
    parameter int               IN_W  = 4,
    parameter int               OUT_W = 2,
    parameter int               HOLD  = 5,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              gray_mode,
    output logic [IN_W-1:0]   vec_out,
    input  logic [OUT_W-1:0]  dut_resp,
    output logic              busy,
    output logic              done,
    output logic              sample_valid,
    output logic [IN_W-1:0]   sample_idx,
    output logic [OUT_W-1:0]  sample_resp,
    output logic [SIG_W-1:0]  signature
);

    // At least one bit even when HOLD=1 (counter then stays at 0).
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t           state;
    logic [IN_W-1:0]  idx;
    logic [HW-1:0]    hold_cnt;
    logic             mode_q;

    logic start_ok;
    logic hold_last;
    logic idx_last;
    logic sample_fire;

    function automatic logic [IN_W-1:0] map_idx(input logic [IN_W-1:0] i, input logic gray);
        logic [15:0] g;
        g = gray_of(16'(i));
        return gray ? g[IN_W-1:0] : i;
    endfunction

    always_comb begin
        start_ok    = start && ((state == IDLE) || (state == DONE));
        hold_last   = (hold_cnt == HW'(HOLD - 1));
        idx_last    = (idx == {IN_W{1'b1}});
        // Abort suppresses a sample falling on the same edge.
        sample_fire = (state == SETTLE) && !abort && hold_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            hold_cnt     <= '0;
            mode_q       <= 1'b0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            sample_resp  <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SETTLE;
                        idx      <= '0;
                        hold_cnt <= '0;
                        mode_q   <= gray_mode;
                        vec_out  <= map_idx('0, gray_mode);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (hold_last) begin
                        sample_valid <= 1'b1;
                        sample_idx   <= idx;
                        sample_resp  <= dut_resp;
                        if (idx_last) begin
                            // Terminal compare: idx never wraps, vec_out keeps the last vector.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx      <= idx + 1'b1;
                            vec_out  <= map_idx(idx + 1'b1, mode_q);
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .DW    (OUT_W)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (sample_fire),
        .din   (dut_resp),
        .sig   (signature)
    );

endmodule

// File: tb/tb_exhaustive_sweep_gen.sv
module tb_exhaustive_sweep_gen;

    // Instance A: default configuration
    localparam int          AIW   = 4;
    localparam int          AOW   = 2;
    localparam int          AHOLD = 5;
    localparam logic [15:0] APOLY = 16'h002D;
    localparam int          ANVEC = 16;

    logic clk;
    logic rst_n;

    logic        start_a, abort_a, gray_mode;
    logic [3:0]  vec_a;
    logic [1:0]  resp_a;
    logic        busy_a, done_a, valid_a;
    logic [3:0]  sidx_a;
    logic [1:0]  sresp_a;
    logic [15:0] sig_a;
    logic [1:0]  tt_a [16];

    // Instance B: IN_W=2, OUT_W=1, SIG_W=4, POLY=3, HOLD=1
    logic        start_b, abort_b, gray_b;
    logic [1:0]  vec_b;
    logic        resp_b;
    logic        busy_b, done_b, valid_b;
    logic [1:0]  sidx_b;
    logic        sresp_b;
    logic [3:0]  sig_b;

    int checks = 0;
    int errors = 0;

    assign resp_a = tt_a[vec_a];
    assign resp_b = 1'b1;

    exhaustive_sweep_gen #(
        .IN_W(AIW), .OUT_W(AOW), .HOLD(AHOLD), .SIG_W(16), .POLY(APOLY)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .gray_mode(gray_mode), .vec_out(vec_a), .dut_resp(resp_a),
        .busy(busy_a), .done(done_a), .sample_valid(valid_a),
        .sample_idx(sidx_a), .sample_resp(sresp_a), .signature(sig_a)
    );

    exhaustive_sweep_gen #(
        .IN_W(2), .OUT_W(1), .HOLD(1), .SIG_W(4), .POLY(4'h3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .gray_mode(gray_b), .vec_out(vec_b), .dut_resp(resp_b),
        .busy(busy_b), .done(done_b), .sample_valid(valid_b),
        .sample_idx(sidx_b), .sample_resp(sresp_b), .signature(sig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: vector for sweep position i and the MISR rule on plain integers.
    function automatic logic [3:0] order_a(input int i, input bit gm);
        int b;
        b = i & 15;
        return gm ? 4'(b ^ (b / 2)) : 4'(b);
    endfunction

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [1:0] r);
        int v;
        v = (int'(s) * 2) % 65536;
        if (s >= 16'h8000) v = v ^ int'(APOLY);
        v = v ^ int'(r);
        return 16'(v);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic randomize_tt();
        for (int i = 0; i < 16; i++) tt_a[i] = 2'($urandom_range(0, 3));
    endtask

    // Full sweep on A with per-cycle checks against the reference.
    // abort_at / spur_start: cycle numbers after acceptance (0 = none).
    task automatic run_sweep_a(input bit gm, input int abort_at, input int spur_start,
                               input bit abort_with_start, output logic [15:0] final_sig);
        int          n;
        int          j;
        logic [15:0] sig;
        logic [3:0]  v;
        n   = ANVEC * AHOLD;
        sig = '0;
        @(negedge clk);
        gray_mode = gm;
        start_a   = 1'b1;
        abort_a   = abort_with_start;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        check("a_accept_vec",   32'(vec_a),   32'(order_a(0, gm)));
        check("a_accept_busy",  32'(busy_a),  32'd1);
        check("a_accept_done",  32'(done_a),  32'd0);
        check("a_accept_sig",   32'(sig_a),   32'd0);
        check("a_accept_valid", 32'(valid_a), 32'd0);
        for (int k = 1; k <= n; k++) begin
            start_a   = (k == spur_start);
            abort_a   = (k == abort_at);
            gray_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start_a = 1'b0;
            abort_a = 1'b0;
            if (k == abort_at) begin
                check("abort_busy",  32'(busy_a),  32'd0);
                check("abort_done",  32'(done_a),  32'd0);
                check("abort_valid", 32'(valid_a), 32'd0);
                check("abort_sig",   32'(sig_a),   32'(sig));
                check("abort_vec",   32'(vec_a),   32'(order_a(min_i((k - 1) / AHOLD, ANVEC - 1), gm)));
                final_sig = sig;
                return;
            end
            if (k % AHOLD == 0) begin
                j   = k / AHOLD - 1;
                v   = order_a(j, gm);
                sig = misr_ref(sig, tt_a[v]);
                check("sample_valid", 32'(valid_a), 32'd1);
                check("sample_idx",   32'(sidx_a),  32'(j));
                check("sample_resp",  32'(sresp_a), 32'(tt_a[v]));
                check("signature",    32'(sig_a),   32'(sig));
            end else begin
                check("no_sample", 32'(valid_a), 32'd0);
            end
            check("vec_out", 32'(vec_a),  32'(order_a(min_i(k / AHOLD, ANVEC - 1), gm)));
            check("busy",    32'(busy_a), 32'(k < n));
            check("done",    32'(done_a), 32'(k == n));
        end
        final_sig = sig;
    endtask

    typedef struct {
        logic [1:0] vec;
        logic       valid;
        logic [1:0] idx;
        logic [3:0] sig;
        logic       busy;
        logic       done;
    } row_t;

    row_t tbl [6];

    initial begin
        logic [15:0] s1, s2, s3, s_dummy;

        tbl[0] = '{vec: 2'd0, valid: 1'b0, idx: 2'd0, sig: 4'h0, busy: 1'b1, done: 1'b0};
        tbl[1] = '{vec: 2'd1, valid: 1'b1, idx: 2'd0, sig: 4'h1, busy: 1'b1, done: 1'b0};
        tbl[2] = '{vec: 2'd2, valid: 1'b1, idx: 2'd1, sig: 4'h3, busy: 1'b1, done: 1'b0};
        tbl[3] = '{vec: 2'd3, valid: 1'b1, idx: 2'd2, sig: 4'h7, busy: 1'b1, done: 1'b0};
        tbl[4] = '{vec: 2'd3, valid: 1'b1, idx: 2'd3, sig: 4'hF, busy: 1'b0, done: 1'b1};
        tbl[5] = '{vec: 2'd3, valid: 1'b0, idx: 2'd3, sig: 4'hF, busy: 1'b0, done: 1'b1};

        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; gray_mode = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; gray_b = 1'b0;
        randomize_tt();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec",   32'(vec_a),   32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_sig",   32'(sig_a),   32'd0);
        check("rst_sidx",  32'(sidx_a),  32'd0);
        check("rst_sresp", 32'(sresp_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // HOLD=1 back-to-back sweep on B, twice (second start accepted from DONE).
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            for (int r = 0; r < 6; r++) begin
                if (r > 0) begin
                    @(posedge clk); #1;
                end
                check("b_vec",   32'(vec_b),   32'(tbl[r].vec));
                check("b_valid", 32'(valid_b), 32'(tbl[r].valid));
                check("b_sig",   32'(sig_b),   32'(tbl[r].sig));
                check("b_busy",  32'(busy_b),  32'(tbl[r].busy));
                check("b_done",  32'(done_b),  32'(tbl[r].done));
                if (tbl[r].valid) begin
                    check("b_idx",  32'(sidx_b),  32'(tbl[r].idx));
                    check("b_resp", 32'(sresp_b), 32'd1);
                end
            end
        end

        // Binary then Gray, then rerun Gray from DONE with start+abort together.
        run_sweep_a(1'b0, 0, 0, 1'b0, s1);
        run_sweep_a(1'b1, 0, 0, 1'b0, s2);
        run_sweep_a(1'b1, 0, 0, 1'b1, s3);
        check("rerun_same_sig", 32'(s3), 32'(s2));

        // Spurious starts mid-sweep are ignored.
        for (int t = 0; t < 3; t++) begin
            run_sweep_a(1'($urandom_range(0, 1)), 0, int'($urandom_range(1, ANVEC * AHOLD - 1)), 1'b0, s_dummy);
        end

        // Abort on a sample edge, then stay idle, then restart cleanly.
        run_sweep_a(1'b0, 2 * AHOLD, 0, 1'b0, s_dummy);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("idle_after_abort_valid", 32'(valid_a), 32'd0);
            check("idle_after_abort_busy",  32'(busy_a),  32'd0);
            check("idle_after_abort_done",  32'(done_a),  32'd0);
        end
        run_sweep_a(1'b0, 0, 0, 1'b0, s_dummy);

        // Abort at an arbitrary cycle, restart from IDLE.
        run_sweep_a(1'b1, 7, 0, 1'b0, s_dummy);
        run_sweep_a(1'b1, 0, 0, 1'b0, s_dummy);

        // Random truth tables and orders.
        for (int t = 0; t < 4; t++) begin
            randomize_tt();
            run_sweep_a(1'($urandom_range(0, 1)), 0, 0, 1'b0, s_dummy);
        end

        // Asynchronous reset between edges in the middle of a hold.
        @(negedge clk);
        gray_mode = 1'b1;
        start_a   = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vec",    32'(vec_a),   32'd0);
        check("arst_busy",   32'(busy_a),  32'd0);
        check("arst_done",   32'(done_a),  32'd0);
        check("arst_valid",  32'(valid_a), 32'd0);
        check("arst_sig",    32'(sig_a),   32'd0);
        check("arst_sidx",   32'(sidx_a),  32'd0);
        check("arst_sresp",  32'(sresp_a), 32'd0);
        check("arst_b_done", 32'(done_b),  32'd0);
        check("arst_b_sig",  32'(sig_b),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("post_rst_busy",  32'(busy_a),  32'd0);
            check("post_rst_done",  32'(done_a),  32'd0);
            check("post_rst_valid", 32'(valid_a), 32'd0);
        end
        run_sweep_a(1'b0, 0, 0, 1'b0, s_dummy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
